// File: rtl/cia_cla_multiword_sequencer_if.sv
// Operand/result handshake bundle for the multiword carry-increment sequencer.
// The master drives operands and result acceptance. The slave (the sequencer) drives the result.
interface cia_cla_multiword_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int WORDS = 2
);
  localparam int TW = WIDTH * WORDS;

  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] a;
  logic [TW-1:0] b;
  logic          carry_in;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] sum;
  logic          carry_out;
  logic          busy;

  modport master (
    output in_valid, a, b, carry_in, out_ready,
    input  in_ready, out_valid, sum, carry_out, busy
  );

  modport slave (
    input  in_valid, a, b, carry_in, out_ready,
    output in_ready, out_valid, sum, carry_out, busy
  );
endinterface

// File: rtl/cia_cla_multiword_sequencer.sv
// Word-serial wide adder. One WIDTH-bit carry-increment adder is reused across
// WORDS cycles. The least-significant word is added first, and the carry is registered between slices.

// Lookahead group: local carries assume a carry-in of 0. The real group
// carry-in is then added as a single increment.
module cia_cla_group #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W-1:0] g, p, s0;
  logic [W:0]   c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    for (int i = 0; i < W; i++) c[i+1] = g[i] | (p[i] & c[i]);
    s0   = p ^ c[W-1:0];
  end

  // The increment can only ripple out of the group when every bit propagates.
  assign sum  = s0 + W'(cin);
  assign cout = c[W] | (cin & (&p));
endmodule

module carry_increment_adder_cla #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int GW = 4;
  localparam int NG = (WIDTH + GW - 1) / GW;

  logic [NG:0] gc;
  assign gc[0] = cin;

  for (genvar g = 0; g < NG; g++) begin : g_grp
    localparam int LO = g * GW;
    localparam int GWI = (LO + GW <= WIDTH) ? GW : (WIDTH - LO);
    cia_cla_group #(.W(GWI)) u_grp (
      .a    (a[LO +: GWI]),
      .b    (b[LO +: GWI]),
      .cin  (gc[g]),
      .sum  (sum[LO +: GWI]),
      .cout (gc[g+1])
    );
  end

  assign cout = gc[NG];
endmodule

module cia_cla_multiword_sequencer #(
  parameter int WIDTH = 16,
  parameter int WORDS = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  cia_cla_multiword_sequencer_if.slave  bus
);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;

  st_t                         st, st_nxt;
  logic [WORDS-1:0][WIDTH-1:0] a_r, b_r, sum_r;
  logic [IW-1:0]               idx;
  logic                        cy_r, cout_r;
  logic [WIDTH-1:0]            a_sl, b_sl, s_sl;
  logic                        c_sl, last, accept;

  assign accept = (st == IDLE) && bus.in_valid;
  assign last   = (idx == IW'(WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (bus.in_valid)  st_nxt = RUN;
      RUN:     if (last)          st_nxt = DONE;
      DONE:    if (bus.out_ready) st_nxt = IDLE;
      default:                    st_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (st == IDLE);
    bus.busy      = (st != IDLE);
    bus.out_valid = (st == DONE);
  end

  // Word select is a compare-per-word mux, so the index never exceeds the array bounds.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (idx == IW'(w)) begin
        a_sl = a_r[w];
        b_sl = b_r[w];
      end
    end
  end

  carry_increment_adder_cla #(.WIDTH(WIDTH)) u_add (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (cy_r),
    .sum  (s_sl),
    .cout (c_sl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      idx    <= '0;
      cy_r   <= 1'b0;
      cout_r <= 1'b0;
    end else if (accept) begin
      a_r    <= bus.a;
      b_r    <= bus.b;
      cy_r   <= bus.carry_in;
      idx    <= '0;
    end else if (st == RUN) begin
      cy_r   <= c_sl;
      idx    <= last ? '0 : idx + 1'b1;
      if (last) cout_r <= c_sl;
    end
  end

  for (genvar w = 0; w < WORDS; w++) begin : g_sum
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           sum_r[w] <= '0;
      else if (st == RUN && idx == IW'(w))  sum_r[w] <= s_sl;
    end
  end

  assign bus.sum       = sum_r;
  assign bus.carry_out = cout_r;
endmodule

// File: tb/tb_cia_cla_multiword_sequencer.sv
// Randomized bench for the word-serial adder: a two-word and a one-word instance,
// checked against plain wide arithmetic.
module tb_cia_cla_multiword_sequencer;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cia_cla_multiword_sequencer_if #(.WIDTH(16), .WORDS(2)) b2 ();
  cia_cla_multiword_sequencer_if #(.WIDTH(16), .WORDS(1)) b1 ();

  cia_cla_multiword_sequencer #(.WIDTH(16), .WORDS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
  cia_cla_multiword_sequencer #(.WIDTH(16), .WORDS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset2(input string tag);
    check({tag, "_sum"},   64'(b2.sum), 64'h0);
    check({tag, "_cout"},  64'(b2.carry_out), 64'h0);
    check({tag, "_oval"},  64'(b2.out_valid), 64'h0);
    check({tag, "_irdy"},  64'(b2.in_ready), 64'h1);
    check({tag, "_busy"},  64'(b2.busy), 64'h0);
  endtask

  // Wide operation on the two-word instance; hold = cycles of backpressure in DONE.
  task automatic op2(input logic [31:0] a, input logic [31:0] b, input logic cin, input int hold);
    logic [32:0] exp;
    int lat;
    exp = {1'b0, a} + {1'b0, b} + 33'(cin);
    @(negedge clk);
    check("op2_irdy_idle", 64'(b2.in_ready), 64'h1);
    b2.a = a; b2.b = b; b2.carry_in = cin; b2.in_valid = 1'b1;
    @(posedge clk); #1;
    b2.in_valid = 1'b0;
    b2.a = $urandom; b2.b = $urandom; b2.carry_in = 1'($urandom);
    check("op2_busy", 64'(b2.busy), 64'h1);
    check("op2_irdy_run", 64'(b2.in_ready), 64'h0);
    lat = 0;
    while (!b2.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("op2_latency", 64'(lat), 64'd2);
    check("op2_sum",  64'(b2.sum), 64'(exp[31:0]));
    check("op2_cout", 64'(b2.carry_out), 64'(exp[32]));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      b2.in_valid = 1'($urandom); b2.a = $urandom; b2.b = $urandom; b2.carry_in = 1'($urandom);
      @(posedge clk); #1;
      check("bp_oval", 64'(b2.out_valid), 64'h1);
      check("bp_irdy", 64'(b2.in_ready), 64'h0);
      check("bp_sum",  64'(b2.sum), 64'(exp[31:0]));
      check("bp_cout", 64'(b2.carry_out), 64'(exp[32]));
    end
    @(negedge clk);
    b2.in_valid = 1'b0; b2.out_ready = 1'b1;
    @(posedge clk); #1;
    check("drain_oval", 64'(b2.out_valid), 64'h0);
    check("drain_irdy", 64'(b2.in_ready), 64'h1);
    check("drain_busy", 64'(b2.busy), 64'h0);
    check("idle_sum_kept", 64'(b2.sum), 64'(exp[31:0]));
    @(negedge clk);
    b2.out_ready = 1'b0;
  endtask

  task automatic op1(input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] exp;
    int lat;
    exp = {1'b0, a} + {1'b0, b} + 17'(cin);
    @(negedge clk);
    b1.a = a; b1.b = b; b1.carry_in = cin; b1.in_valid = 1'b1;
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
    lat = 0;
    while (!b1.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("op1_latency", 64'(lat), 64'd1);
    check("op1_sum",  64'(b1.sum), 64'(exp[15:0]));
    check("op1_cout", 64'(b1.carry_out), 64'(exp[16]));
    @(negedge clk);
    b1.out_ready = 1'b1;
    @(posedge clk); #1;
    check("op1_drain", 64'(b1.out_valid), 64'h0);
    @(negedge clk);
    b1.out_ready = 1'b0;
  endtask

  initial begin
    b2.in_valid = 1'b0; b2.a = '0; b2.b = '0; b2.carry_in = 1'b0; b2.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.a = '0; b1.b = '0; b1.carry_in = 1'b0; b1.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset2("por");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    op2(32'h0000FFFF, 32'h00000001, 1'b0, 0);
    op2(32'hFFFFFFFF, 32'h00000001, 1'b1, 0);
    op2(32'h12345678, 32'h9ABCDEF0, 1'b1, 5);
    for (int i = 0; i < 30; i++)
      op2($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)));

    // Abort in RUN, one cycle after acceptance.
    @(negedge clk);
    b2.a = 32'h1A2B3C4D; b2.b = 32'h3C4D1A2B; b2.carry_in = 1'b0; b2.in_valid = 1'b1;
    @(posedge clk); #1 b2.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1 chk_reset2("rst_run");
    @(negedge clk) rst_n = 1'b1;
    op2(32'h1A2B3C4D, 32'h3C4D1A2B, 1'b0, 0);

    // Abort while holding a result in DONE.
    @(negedge clk);
    b2.a = 32'hFFFF0000; b2.b = 32'h0001FFFF; b2.carry_in = 1'b1; b2.in_valid = 1'b1;
    @(posedge clk); #1 b2.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("pre_rst_done", 64'(b2.out_valid), 64'h1);
    @(negedge clk) rst_n = 1'b0;
    #1 chk_reset2("rst_done");
    @(negedge clk) rst_n = 1'b1;

    op1(16'hFFFF, 16'h0001, 1'b1);
    for (int i = 0; i < 20; i++)
      op1(16'($urandom), 16'($urandom), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
